ic_number_entry_ctrl: RTL



---
 rtl/ic_number_entry_ctrl.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ic_number_entry_ctrl.sv
// ic_number_entry_ctrl
// Front-panel sequencer for entering a 4-digit decimal IC number. The user
// edits the digits with buttons while the digits are shown on four 7-segment
// displays. Confirm strobes the pattern-to-number converter (ic_read) and
// waits, with a timeout, for its acknowledge. The block then reports done or
// error to the test sequencer.
//
// Ports:
//   clk              system clock
//   reset            asynchronous, active-high reset
//   btn_inc          debounced level; a rising edge increments the cursor digit
//   btn_next         debounced level; a rising edge moves the cursor left (3 wraps to 0)
//   btn_confirm      debounced level; a rising edge starts a conversion
//   btn_clear        debounced level; a rising edge zeroes everything and returns to edit
//   ic_no_generated  converter acknowledge (level)
//   HEX0..HEX3       active-low 7-segment patterns (HEX3 = thousands)
//   ic_read          strobe to the converter
//   bcd_digits       {d3,d2,d1,d0}, 4 bits each
//   cursor           digit under edit
//   busy             high while strobing or waiting for the acknowledge
//   entry_done       high after a successful conversion
//   entry_error      high after an acknowledge timeout
module ic_number_entry_ctrl #(
  parameter int READ_PULSE  = 4,
  parameter int ACK_TIMEOUT = 1000,
  parameter int BLINK_DIV   = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_inc,
  input  logic        btn_next,
  input  logic        btn_confirm,
  input  logic        btn_clear,
  input  logic        ic_no_generated,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic        ic_read,
  output logic [15:0] bcd_digits,
  output logic [1:0]  cursor,
  output logic        busy,
  output logic        entry_done,
  output logic        entry_error
);

  localparam int PW = $clog2(READ_PULSE + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [PW-1:0] PULSE_LOAD = PW'(READ_PULSE);
  localparam logic [PW-1:0] PULSE_ONE  = PW'(1);
  localparam logic [TW-1:0] TMO_LOAD   = TW'(ACK_TIMEOUT);
  localparam logic [TW-1:0] TMO_ONE    = TW'(1);
  localparam logic [BLINK_DIV-1:0] BLINK_ONE = BLINK_DIV'(1);

  // Bit positions inside the button vectors.
  localparam int B_INC     = 0;
  localparam int B_NEXT    = 1;
  localparam int B_CONFIRM = 2;
  localparam int B_CLEAR   = 3;

  typedef enum logic [2:0] {
    ST_EDIT     = 3'd0,
    ST_STROBE   = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_DONE     = 3'd3,
    ST_ERROR    = 3'd4
  } state_t;

  // Active-low segment pattern (bits g..a) of one BCD digit.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0011000;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  logic [3:0]           btn_s, sync1_r, sync2_r, sync_d_r, edge_s;
  state_t               state_r, state_next_s;
  logic [15:0]          digits_r, digits_next_s;
  logic [1:0]           cursor_r, cursor_next_s;
  logic [3:0]           cur_digit_s;
  logic [PW-1:0]        pulse_cnt_r, pulse_next_s;
  logic [TW-1:0]        tmo_cnt_r, tmo_next_s;
  logic [BLINK_DIV-1:0] blink_cnt_r, blink_next_s;
  logic [3:0][6:0]      hex_r, hex_next_s;
  logic                 ic_read_r, busy_r, done_r, err_r;

  assign btn_s  = {btn_clear, btn_confirm, btn_next, btn_inc};
  // One-cycle pulse on the first synchronised cycle of a press.
  assign edge_s = sync2_r & ~sync_d_r;

  // Two-flop synchroniser plus a delayed copy for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r  <= 4'b0000;
      sync2_r  <= 4'b0000;
      sync_d_r <= 4'b0000;
    end else begin
      sync1_r  <= btn_s;
      sync2_r  <= sync1_r;
      sync_d_r <= sync2_r;
    end
  end

  // Next-state logic. Clear outranks every other action, and within a state
  // the order is confirm > next > inc.
  always_comb begin
    state_next_s  = state_r;
    digits_next_s = digits_r;
    cursor_next_s = cursor_r;
    pulse_next_s  = pulse_cnt_r;
    tmo_next_s    = tmo_cnt_r;
    cur_digit_s   = digits_r[{cursor_r, 2'b00} +: 4];
    if (edge_s[B_CLEAR]) begin
      state_next_s  = ST_EDIT;
      digits_next_s = 16'h0000;
      cursor_next_s = 2'd0;
      pulse_next_s  = '0;
      tmo_next_s    = '0;
    end else begin
      case (state_r)
        ST_EDIT: begin
          if (edge_s[B_CONFIRM]) begin
            state_next_s = ST_STROBE;
            pulse_next_s = PULSE_LOAD;
          end else if (edge_s[B_NEXT]) begin
            cursor_next_s = cursor_r + 2'd1;
          end else if (edge_s[B_INC]) begin
            // The >= keeps the digit valid BCD even if it were ever corrupted.
            digits_next_s[{cursor_r, 2'b00} +: 4] =
              (cur_digit_s >= 4'd9) ? 4'd0 : cur_digit_s + 4'd1;
          end else begin
            state_next_s = ST_EDIT;
          end
        end
        ST_STROBE: begin
          if (pulse_cnt_r <= PULSE_ONE) begin
            state_next_s = ST_WAIT_ACK;
            pulse_next_s = '0;
            tmo_next_s   = TMO_LOAD;
          end else begin
            pulse_next_s = pulse_cnt_r - PULSE_ONE;
          end
        end
        ST_WAIT_ACK: begin
          // The acknowledge wins over a timeout expiring in the same cycle.
          if (ic_no_generated) begin
            state_next_s = ST_DONE;
            tmo_next_s   = '0;
          end else if (tmo_cnt_r <= TMO_ONE) begin
            state_next_s = ST_ERROR;
            tmo_next_s   = '0;
          end else begin
            tmo_next_s = tmo_cnt_r - TMO_ONE;
          end
        end
        ST_DONE, ST_ERROR: begin
          if (edge_s[B_CONFIRM]) begin
            state_next_s = ST_STROBE;
            pulse_next_s = PULSE_LOAD;
          end else begin
            state_next_s = state_r;
          end
        end
        default: begin
          state_next_s  = ST_EDIT;
          digits_next_s = 16'h0000;
          cursor_next_s = 2'd0;
        end
      endcase
    end
  end

  // Output decode from the next state, so the registered outputs change on
  // the same edge as the state they describe.
  always_comb begin
    blink_next_s = blink_cnt_r + BLINK_ONE;
    for (int i = 0; i < 4; i++) begin
      hex_next_s[i] = ((state_next_s == ST_EDIT) && (cursor_next_s == 2'(i)) &&
                       blink_next_s[BLINK_DIV-1]) ? 7'b1111111
                                                   : seg7(digits_next_s[4*i +: 4]);
    end
  end

  // State, digit, cursor and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_EDIT;
      digits_r    <= 16'h0000;
      cursor_r    <= 2'd0;
      pulse_cnt_r <= '0;
      tmo_cnt_r   <= '0;
      blink_cnt_r <= '0;
    end else begin
      state_r     <= state_next_s;
      digits_r    <= digits_next_s;
      cursor_r    <= cursor_next_s;
      pulse_cnt_r <= pulse_next_s;
      tmo_cnt_r   <= tmo_next_s;
      blink_cnt_r <= blink_next_s;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex_r     <= {4{7'b1000000}};
      ic_read_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      hex_r     <= hex_next_s;
      ic_read_r <= (state_next_s == ST_STROBE);
      busy_r    <= (state_next_s == ST_STROBE) || (state_next_s == ST_WAIT_ACK);
      done_r    <= (state_next_s == ST_DONE);
      err_r     <= (state_next_s == ST_ERROR);
    end
  end

  assign HEX0        = hex_r[0];
  assign HEX1        = hex_r[1];
  assign HEX2        = hex_r[2];
  assign HEX3        = hex_r[3];
  assign ic_read     = ic_read_r;
  assign busy        = busy_r;
  assign entry_done  = done_r;
  assign entry_error = err_r;
  assign bcd_digits  = digits_r;
  assign cursor      = cursor_r;

endmodule
